spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

SPI mode-0 receiver: the peripheral-side counterpart of the team's SPI master transmitter. It oversamples the externally driven SCLK, MOSI and CS lines in the system `clk` domain and assembles serial bits into words. It presents each completed word on a valid/ready handshake to downstream logic. It flags dropped words (overrun) and frames truncated by an early CS release.

## Interface
- `DATA_W`, default 8: bits per word.
- `LSB_FIRST`, default 1: 1 means the first received bit lands in `rx_data[0]`; 0 means it lands in `rx_data[DATA_W-1]`.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers (minimum 2).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `SCLK`  in  1  serial clock from the master; asynchronous to `clk`.
- `MOSI`  in  1  serial data from the master; asynchronous.
- `CS`  in  1  chip select, active low; asynchronous.
- `rx_data`  out  DATA_W  holding register for the last accepted word.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  the consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `frame_err`  out  1  one-cycle pulse: CS deasserted with a partial word.
- `busy`  out  1  high while the synchronized CS is low.

## Operation
- **Synchronizers.** `SCLK`, `MOSI` and `CS` each pass through `SYNC_STAGES` flops, producing `sclk_s`, `mosi_s` and `cs_s`. Reset values: `SCLK` chain 1, `CS` chain 1, `MOSI` chain 0. All three chains have equal depth, so `mosi_s` stays aligned with `sclk_s`.
- **Edge detect.** `sclk_q` holds `sclk_s` delayed by one cycle. `sclk_rise = sclk_s & ~sclk_q`. Falling edges are ignored.
- **State machine.** States are IDLE and SHIFT.
  - IDLE → SHIFT when `cs_s` == 0. On entry, `bit_cnt` and the shift register clear to 0.
  - SHIFT → IDLE when `cs_s` == 1.
  - If `bit_cnt` != 0 at that exit, `frame_err` pulses for one cycle and the partial word is discarded.
  - If `bit_cnt` == 0 at that exit, the frame ended cleanly and there is no pulse.
- **Shifting.** In SHIFT, each `sclk_rise` samples `mosi_s` into the shift register at the position set by `LSB_FIRST`, and `bit_cnt` increments.
  - `bit_cnt` is `$clog2(DATA_W)+1` bits wide.
  - When the sample that makes the count equal `DATA_W` occurs, a completion event fires and `bit_cnt` wraps to 0.
  - Back-to-back words within one CS-low frame are supported.
- **`sclk_rise` in IDLE** has no effect.
- **Completion event.**
  - If `rx_valid` == 0, or `rx_ready` == 1 in the same cycle: `rx_data` ← the assembled word and `rx_valid` ← 1.
  - Otherwise: the word is dropped, `rx_data` and `rx_valid` are unchanged, and `overrun` pulses.
- **Handshake.**
  - `rx_valid` clears the cycle after `rx_valid && rx_ready`, unless a completion event loads a new word in that same cycle.
  - `rx_data` is stable while `rx_valid` is high and unaccepted.
- **Reset.** Assertion of `rst_n` at any time, including mid-word, forces IDLE. All outputs read 0: `rx_data`, `rx_valid`, `overrun`, `frame_err`, `busy`. The partial word is lost without a `frame_err` pulse.

## Timing
- Latency from the external SCLK rising edge to the sample is `SYNC_STAGES`+1 `clk` cycles.
- After the final bit's sample, `rx_valid` rises on the next `clk` edge.
- `busy` follows `CS` with `SYNC_STAGES` cycles of latency.
- Input requirements on the master:
  - SCLK high and low phases each ≥ `SYNC_STAGES`+1 `clk` periods.
  - MOSI stable from its SCLK falling-edge update until after the rising edge, which holds given the phase rule.
  - The CS-fall to first rising edge spacing and the last rising edge to CS-rise spacing are each ≥ `SYNC_STAGES`+1 cycles.
- Nominal operation: 1 MHz SCLK with a 50 MHz `clk`. The block must also work at `clk` = 8 × SCLK.
- `overrun` and `frame_err` are exactly one cycle wide and never high in the same cycle as each other.

## Test plan
- Default parameters; CS low, 8 mode-0 bits of 0x4C sent LSB-first, CS high → `rx_data`=0x4C, `rx_valid`=1 one cycle after the 8th sample, no `overrun` or `frame_err` pulse.
- `LSB_FIRST`=0; send 0xA5 MSB-first → `rx_data`=0xA5. Then `rx_ready` pulsed → `rx_valid` drops the next cycle.
- One CS frame carrying 0x12, 0x34 with `rx_ready` held 0 → `rx_data` stays 0x12, one `overrun` pulse at the second completion. A third byte 0x56, sent after `rx_ready` pulses once, is received as 0x56.
- `rx_ready` asserted exactly in the completion cycle of the second byte (0x34 following 0x12) → `rx_valid` stays 1, `rx_data`=0x34, no `overrun`.
- 5 bits sent, then CS high → one `frame_err` pulse, `rx_valid` unchanged. A following full frame of 0xFF → `rx_data`=0xFF (no stale bits).
- `rst_n` pulsed low after 4 bits of a frame → all outputs 0 immediately (asynchronously). A fresh frame of 0x81 → `rx_data`=0x81.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver. SCLK/MOSI/CS are oversampled in the clk domain.
// Received words are presented on a valid/ready holding register.
// overrun pulses when a completed word has to be dropped.
// frame_err pulses when CS rises in the middle of a word.
// DATA_W must be at least 2.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              CS,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic                   sclk_q, sclk_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, mosi_s, cs_s, sclk_rise;

  // All three lines see the same sync depth, so MOSI stays aligned with SCLK.
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;

  // Next-state: synchronizers, receive FSM, shift register and output handshake.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    sclk_d      = sclk_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    // A consumed word frees the holding register; a same-cycle load below wins.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          // A partial word is discarded; the next entry clears the shifter.
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          if (LSB_FIRST != 0) shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
          else                shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == CW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shreg_d;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. SCLK/CS idle high so that reset release creates no false edge or frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_q      <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_q      <= sclk_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = ~cs_s;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an LSB-first and an MSB-first instance share one SPI bus.
// It runs a vector table, hand-written corner sequences and randomized frames.
// The randomized frames are checked against a word-level reference model.
module tb_spi_slave_rx;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n, SCLK, MOSI, CS, rx_ready;
  logic [7:0] rx_data_l, rx_data_m;
  logic rx_valid_l, rx_valid_m, ovr_l, ovr_m, ferr_l, ferr_m, busy_l, busy_m;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(8), .LSB_FIRST(1), .SYNC_STAGES(SYNC)) u_lsb (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready),
    .overrun(ovr_l), .frame_err(ferr_l), .busy(busy_l));

  spi_slave_rx #(.DATA_W(8), .LSB_FIRST(0), .SYNC_STAGES(SYNC)) u_msb (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
    .rx_data(rx_data_m), .rx_valid(rx_valid_m), .rx_ready(rx_ready),
    .overrun(ovr_m), .frame_err(ferr_m), .busy(busy_m));

  // Pulse counters; the tests take snapshots and compare deltas.
  int ovr_l_n = 0, ovr_m_n = 0, ferr_l_n = 0, ferr_m_n = 0, both_n = 0;
  always @(posedge clk) begin
    if (ovr_l)  ovr_l_n  <= ovr_l_n + 1;
    if (ovr_m)  ovr_m_n  <= ovr_m_n + 1;
    if (ferr_l) ferr_l_n <= ferr_l_n + 1;
    if (ferr_m) ferr_m_n <= ferr_m_n + 1;
    if ((ovr_l & ferr_l) | (ovr_m & ferr_m)) both_n <= both_n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int hp       = 4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: data is set while SCLK is low and sampled on the rise.
  task automatic send_bit(input logic b);
    MOSI = b;
    tick(hp);
    SCLK = 1'b1;
    tick(hp);
    SCLK = 1'b0;
  endtask

  // s[i] is the i-th bit on the wire.
  task automatic send_stream(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) send_bit(s[i]);
  endtask

  task automatic cs_low();
    CS = 1'b0;
    tick(1);
  endtask

  task automatic cs_high();
    tick(hp);
    CS = 1'b1;
    tick(SYNC + 3);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
  endtask

  // Reference: the MSB-first receiver holds the wire order bit-reversed.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  typedef struct {
    logic [7:0] s;
    int         n;
    bit         pre_consume;
    bit         exp_v;
    logic [7:0] exp_l;
    logic [7:0] exp_m;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int o_l, o_m, f_l, f_m;
    logic [7:0] w, w0;
    int nw, extra;
    bit hold;

    tbl[0] = '{8'h4C, 8, 1'b1, 1'b1, 8'h4C, 8'h32, 0};
    tbl[1] = '{8'hA5, 8, 1'b1, 1'b1, 8'hA5, 8'hA5, 0};
    tbl[2] = '{8'h01, 8, 1'b1, 1'b1, 8'h01, 8'h80, 0};
    tbl[3] = '{8'hF0, 8, 1'b1, 1'b1, 8'hF0, 8'h0F, 0};
    tbl[4] = '{8'h1F, 5, 1'b0, 1'b1, 8'hF0, 8'h0F, 1};
    tbl[5] = '{8'hFF, 8, 1'b1, 1'b1, 8'hFF, 8'hFF, 0};
    tbl[6] = '{8'h1A, 3, 1'b1, 1'b0, 8'h00, 8'h00, 1};
    tbl[7] = '{8'h00, 0, 1'b1, 1'b0, 8'h00, 8'h00, 0};
    tbl[8] = '{8'h3C, 8, 1'b1, 1'b1, 8'h3C, 8'h3C, 0};

    rst_n = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; rx_ready = 1'b0;
    tick(3);
    chk("reset_data",  32'(rx_data_l), 32'h0);
    chk("reset_valid", 32'(rx_valid_l), 32'h0);
    chk("reset_flags", 32'({ovr_l, ferr_l, busy_l, ovr_m, ferr_m, busy_m}), 32'h0);
    rst_n = 1'b1;
    tick(SYNC + 3);

    // Exact latency: rx_valid rises SYNC+1 edges after the final SCLK rise.
    o_l = ovr_l_n; f_l = ferr_l_n;
    cs_low();
    send_stream(32'h4C, 7);
    chk("busy_in_frame", 32'(busy_l), 32'h1);
    MOSI = 1'b0;
    tick(hp);
    SCLK = 1'b1;
    tick(SYNC);
    chk("lat_before", 32'(rx_valid_l), 32'h0);
    tick(1);
    chk("lat_valid", 32'(rx_valid_l), 32'h1);
    chk("lat_data",  32'(rx_data_l), 32'h4C);
    tick(hp - SYNC - 1);
    SCLK = 1'b0;
    cs_high();
    chk("lat_busy_off", 32'(busy_l), 32'h0);
    chk("lat_no_pulses", 32'((ovr_l_n - o_l) + (ferr_l_n - f_l)), 32'h0);

    // A ready pulse drops rx_valid on the following edge.
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("consume_valid", 32'(rx_valid_l), 32'h0);

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].pre_consume) consume();
      o_l = ovr_l_n; o_m = ovr_m_n; f_l = ferr_l_n; f_m = ferr_m_n;
      cs_low();
      send_stream(32'(tbl[i].s), tbl[i].n);
      cs_high();
      chk($sformatf("vec%0d_valid_l", i), 32'(rx_valid_l), 32'(tbl[i].exp_v));
      chk($sformatf("vec%0d_valid_m", i), 32'(rx_valid_m), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        chk($sformatf("vec%0d_data_l", i), 32'(rx_data_l), 32'(tbl[i].exp_l));
        chk($sformatf("vec%0d_data_m", i), 32'(rx_data_m), 32'(tbl[i].exp_m));
      end
      chk($sformatf("vec%0d_ferr_l", i), 32'(ferr_l_n - f_l), 32'(tbl[i].exp_ferr));
      chk($sformatf("vec%0d_ferr_m", i), 32'(ferr_m_n - f_m), 32'(tbl[i].exp_ferr));
      chk($sformatf("vec%0d_ovr", i), 32'((ovr_l_n - o_l) + (ovr_m_n - o_m)), 32'h0);
    end

    // Overrun: the second word of a frame is dropped while rx_ready is low.
    consume();
    o_l = ovr_l_n; o_m = ovr_m_n; f_l = ferr_l_n;
    cs_low();
    send_stream(32'h12, 8);
    send_stream(32'h34, 8);
    chk("ovr_data_held", 32'(rx_data_l), 32'h12);
    chk("ovr_valid", 32'(rx_valid_l), 32'h1);
    chk("ovr_pulse_l", 32'(ovr_l_n - o_l), 32'h1);
    chk("ovr_pulse_m", 32'(ovr_m_n - o_m), 32'h1);
    consume();
    send_stream(32'h56, 8);
    cs_high();
    chk("ovr_third_data", 32'(rx_data_l), 32'h56);
    chk("ovr_third_valid", 32'(rx_valid_l), 32'h1);
    chk("ovr_no_more", 32'(ovr_l_n - o_l), 32'h1);
    chk("ovr_no_ferr", 32'(ferr_l_n - f_l), 32'h0);

    // rx_ready asserted exactly in the completion cycle of the second word.
    consume();
    o_l = ovr_l_n;
    cs_low();
    send_stream(32'h12, 8);
    send_stream(32'h34, 7);
    MOSI = 1'b0;
    tick(hp);
    SCLK = 1'b1;
    tick(SYNC);
    chk("rdy_edge_before", 32'(rx_data_l), 32'h12);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("rdy_edge_valid", 32'(rx_valid_l), 32'h1);
    chk("rdy_edge_data", 32'(rx_data_l), 32'h34);
    tick(hp - SYNC - 1);
    SCLK = 1'b0;
    cs_high();
    chk("rdy_edge_no_ovr", 32'(ovr_l_n - o_l), 32'h0);

    // Asynchronous reset in the middle of a word, with a valid word held.
    f_l = ferr_l_n;
    cs_low();
    send_stream(32'h0F, 4);
    rst_n = 1'b0;
    #1;
    chk("arst_data_l", 32'(rx_data_l), 32'h0);
    chk("arst_data_m", 32'(rx_data_m), 32'h0);
    chk("arst_flags", 32'({rx_valid_l, ovr_l, ferr_l, busy_l, rx_valid_m, busy_m}), 32'h0);
    CS = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(SYNC + 3);
    cs_low();
    send_stream(32'h81, 8);
    cs_high();
    chk("arst_fresh_data", 32'(rx_data_l), 32'h81);
    chk("arst_fresh_valid", 32'(rx_valid_l), 32'h1);
    chk("arst_no_ferr", 32'(ferr_l_n - f_l), 32'h0);

    // Randomized frames against the word-level model.
    for (int it = 0; it < 24; it++) begin
      hp    = int'($urandom_range(3, 6));
      nw    = int'($urandom_range(1, 3));
      hold  = 1'($urandom_range(0, 1));
      extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      consume();
      o_l = ovr_l_n; o_m = ovr_m_n; f_l = ferr_l_n; f_m = ferr_m_n;
      w0 = 8'h00;
      cs_low();
      for (int k = 0; k < nw; k++) begin
        w = 8'($urandom);
        if (k == 0) w0 = w;
        send_stream(32'(w), 8);
        if (!hold) begin
          chk($sformatf("rnd%0d_w%0d_l", it, k), 32'(rx_data_l), 32'(w));
          chk($sformatf("rnd%0d_w%0d_m", it, k), 32'(rx_data_m), 32'(rev8(w)));
          consume();
        end
      end
      send_stream($urandom, extra);
      cs_high();
      if (hold) begin
        chk($sformatf("rnd%0d_hold_l", it), 32'(rx_data_l), 32'(w0));
        chk($sformatf("rnd%0d_hold_m", it), 32'(rx_data_m), 32'(rev8(w0)));
        chk($sformatf("rnd%0d_ovr_l", it), 32'(ovr_l_n - o_l), 32'(nw - 1));
        chk($sformatf("rnd%0d_ovr_m", it), 32'(ovr_m_n - o_m), 32'(nw - 1));
      end else begin
        chk($sformatf("rnd%0d_valid", it), 32'(rx_valid_l), 32'h0);
      end
      chk($sformatf("rnd%0d_ferr_l", it), 32'(ferr_l_n - f_l), 32'(extra != 0));
      chk($sformatf("rnd%0d_ferr_m", it), 32'(ferr_m_n - f_m), 32'(extra != 0));
    end

    chk("ovr_ferr_never_together", 32'(both_n), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
